// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler
//   Feeds 2-bit QAM symbols to qam_mixer's data_in. Symbols arrive via a
//   valid/ready handshake into a small FIFO. Each burst starts on a
//   sample_tick that coincides with carrier phase zero. Every symbol is held
//   for SYM_LEN carrier samples. A burst ends after the symbol tagged last.
//   If the FIFO runs dry mid-burst, a 00 filler symbol is sent and the
//   underflow counter increments.
//
// Optional feature macro: QAM_PREAMBLE_EN
//   When defined, each burst opens with PREAMBLE_LEN alternating 00/11
//   symbols before the first data symbol is popped.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active high
//   sample_tick    one-cycle pulse per carrier sample
//   carrier_zero   high while the carrier is at phase index 0
//   sym_in         upstream symbol
//   sym_last       sym_in is the final symbol of its burst
//   sym_valid      upstream offers sym_in/sym_last
//   sym_ready      FIFO can accept a symbol
//   data_out       symbol driven to qam_mixer data_in
//   mix_en         burst on air
//   busy           scheduler not idle
//   sym_count      data symbols transmitted since reset (wraps)
//   underflow_cnt  underflow boundaries since reset (saturates at 255)

module qam_symbol_scheduler #(
    parameter int SYM_LEN      = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PREAMBLE_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        carrier_zero,
    input  logic [1:0]  sym_in,
    input  logic        sym_last,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic [1:0]  data_out,
    output logic        mix_en,
    output logic        busy,
    output logic [15:0] sym_count,
    output logic [7:0]  underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(SYM_LEN);
    localparam logic [TW-1:0] TICK_MAX = TW'(SYM_LEN - 1);

    // Reject configurations the pointer and counter widths cannot represent.
    if (SYM_LEN < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PREAMBLE_LEN < 1) begin : g_bad_cfg
        $error("qam_symbol_scheduler: unsupported parameter set");
    end

`ifdef QAM_PREAMBLE_EN
    localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ALIGN    = 2'd1,
`ifdef QAM_PREAMBLE_EN
        S_PREAMBLE = 2'd2,
`endif
        S_DATA     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Symbol FIFO: entry = {last, sym}. Pointers carry one extra wrap bit
    // so that full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic [2:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic [2:0]  fifo_head;
    logic        push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // Readiness looks only at full, so a full FIFO refuses a push even in
    // a cycle where the scheduler pops.
    assign sym_ready  = !rst && !fifo_full;
    assign push       = sym_valid && sym_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {sym_last, sym_in};
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [1:0]      data_nxt;
    logic            mix_nxt;
    logic            cur_last, last_nxt;   // last flag of the symbol on air
    logic            boundary;
    logic            load_sym;             // boundary that takes the next data symbol
    logic            cnt_inc, uf_inc;
`ifdef QAM_PREAMBLE_EN
    logic [PW-1:0]   pre_idx, pre_nxt;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            data_out      <= 2'b00;
            mix_en        <= 1'b0;
            cur_last      <= 1'b0;
            sym_count     <= '0;
            underflow_cnt <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
`ifdef QAM_PREAMBLE_EN
            pre_idx       <= '0;
`endif
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            data_out <= data_nxt;
            mix_en   <= mix_nxt;
            cur_last <= last_nxt;
`ifdef QAM_PREAMBLE_EN
            pre_idx  <= pre_nxt;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (cnt_inc) sym_count <= sym_count + 16'd1;
            if (uf_inc && underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        data_nxt  = data_out;
        mix_nxt   = mix_en;
        last_nxt  = cur_last;
        load_sym  = 1'b0;
        pop       = 1'b0;
        cnt_inc   = 1'b0;
        uf_inc    = 1'b0;
`ifdef QAM_PREAMBLE_EN
        pre_nxt   = pre_idx;
`endif
        boundary  = sample_tick && (tick_cnt == TICK_MAX);

        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = S_ALIGN;
            end

            S_ALIGN: begin
                // Burst start is locked to a carrier sample at phase zero.
                if (sample_tick && carrier_zero) begin
                    tick_nxt = '0;
                    mix_nxt  = 1'b1;
                    last_nxt = 1'b0;
`ifdef QAM_PREAMBLE_EN
                    state_nxt = S_PREAMBLE;
                    pre_nxt   = '0;
                    data_nxt  = 2'b00;
`else
                    state_nxt = S_DATA;
                    load_sym  = 1'b1;
`endif
                end
            end

`ifdef QAM_PREAMBLE_EN
            S_PREAMBLE: begin
                if (boundary) begin
                    tick_nxt = '0;
                    if (pre_idx == PRE_MAX) begin
                        state_nxt = S_DATA;
                        load_sym  = 1'b1;
                    end else begin
                        // Pattern alternates 00/11 on preamble index parity.
                        pre_nxt  = pre_idx + 1'b1;
                        data_nxt = {2{~pre_idx[0]}};
                    end
                end else if (sample_tick) begin
                    tick_nxt = tick_cnt + 1'b1;
                end
            end
`endif

            S_DATA: begin
                if (boundary) begin
                    tick_nxt = '0;
                    if (cur_last) begin
                        state_nxt = S_IDLE;
                        mix_nxt   = 1'b0;
                        data_nxt  = 2'b00;
                    end else begin
                        load_sym = 1'b1;
                    end
                end else if (sample_tick) begin
                    tick_nxt = tick_cnt + 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        // Take the next data symbol, or fill with 00 when the FIFO is dry.
        // A symbol pushed in this same cycle is not yet visible here.
        if (load_sym) begin
            if (!fifo_empty) begin
                pop      = 1'b1;
                data_nxt = fifo_head[1:0];
                last_nxt = fifo_head[2];
                cnt_inc  = 1'b1;
            end else begin
                data_nxt = 2'b00;
                last_nxt = 1'b0;
                uf_inc   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench for qam_symbol_scheduler (SYM_LEN=4, FIFO_DEPTH=4,
// PREAMBLE_LEN=4). sample_tick fires every 2nd cycle, and carrier_zero
// accompanies every 8th tick. Stray carrier_zero pulses on non-tick cycles
// must be ignored. The reference model tracks the queue of accepted symbols
// and the number of ticks since the burst start. A new symbol slot begins
// every SYM_LEN ticks.

module tb_qam_symbol_scheduler;

    localparam int SYM_LEN      = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int PREAMBLE_LEN = 4;
`ifdef QAM_PREAMBLE_EN
    localparam int PRE = PREAMBLE_LEN;
`else
    localparam int PRE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick, carrier_zero;
    logic [1:0]  sym_in;
    logic        sym_last, sym_valid;
    logic        sym_ready;
    logic [1:0]  data_out;
    logic        mix_en, busy;
    logic [15:0] sym_count;
    logic [7:0]  underflow_cnt;

    qam_symbol_scheduler #(
        .SYM_LEN      (SYM_LEN),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .carrier_zero  (carrier_zero),
        .sym_in        (sym_in),
        .sym_last      (sym_last),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .data_out      (data_out),
        .mix_en        (mix_en),
        .busy          (busy),
        .sym_count     (sym_count),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus queue of {last, sym} and per-cycle observed/expected on-air data.
    logic [2:0] pend[$];
    int         gap_pct = 0;
    logic [1:0] obs[$];
    logic [1:0] expv[$];

    // ---------------- carrier sample generator ----------------
    int ph = 0;
    int tk = 0;
    initial begin
        sample_tick  = 1'b0;
        carrier_zero = 1'b0;
        forever begin
            @(negedge clk);
            ph = 1 - ph;
            if (ph == 1) begin
                sample_tick  = 1'b1;
                carrier_zero = (tk % 8 == 0);
                tk++;
            end else begin
                sample_tick  = 1'b0;
                carrier_zero = ($urandom_range(3) == 0);
            end
        end
    end

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 waiting for phase zero, 2 on air.
    logic [2:0]  mq[$];
    int          m_mode = 0;
    int          m_bt   = 0;
    int          m_n    = 0;
    logic [1:0]  m_data = 2'b00;
    logic        m_mix  = 1'b0;
    logic        m_last = 1'b0;
    logic        m_acc  = 1'b0;
    logic        m_start = 1'b0;
    logic [2:0]  m_hd;
    logic [15:0] m_cnt = 16'd0;
    logic [7:0]  m_uf  = 8'd0;

    always @(posedge clk) begin
        m_acc   = !rst && sym_valid && (mq.size() < FIFO_DEPTH);
        m_start = 1'b0;
        if (rst) begin
            mq.delete();
            m_mode = 0; m_bt = 0; m_data = 2'b00; m_mix = 1'b0; m_last = 1'b0;
            m_cnt = 16'd0; m_uf = 8'd0;
        end else begin
            case (m_mode)
                0: if (mq.size() != 0) m_mode = 1;
                1: if (sample_tick && carrier_zero) begin
                       m_mode = 2; m_bt = 0; m_mix = 1'b1; m_last = 1'b0; m_start = 1'b1;
                   end
                default: if (sample_tick) begin
                       m_bt++;
                       m_start = (m_bt % SYM_LEN == 0);
                   end
            endcase
            if (m_start) begin
                m_n = m_bt / SYM_LEN;
                if (m_n < PRE) begin
                    m_data = {m_n[0], m_n[0]};
                end else if (m_last) begin
                    m_mode = 0; m_mix = 1'b0; m_data = 2'b00;
                end else if (mq.size() != 0) begin
                    m_hd   = mq.pop_front();
                    m_data = m_hd[1:0];
                    m_last = m_hd[2];
                    m_cnt  = m_cnt + 16'd1;
                end else begin
                    m_data = 2'b00;
                    m_last = 1'b0;
                    if (m_uf != 8'hFF) m_uf = m_uf + 8'd1;
                end
            end
            if (m_acc) mq.push_back({sym_last, sym_in});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        if (sym_valid && m_acc) pend.delete(0);
        if (pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
            sym_valid = 1'b1;
            {sym_last, sym_in} = pend[0];
        end else begin
            sym_valid = 1'b0;
        end
    endtask

    function automatic void add_sym(logic [1:0] v);
        for (int k = 0; k < 2 * SYM_LEN; k++) expv.push_back(v);
    endfunction

    function automatic void add_preamble();
        for (int i = 0; i < PRE; i++) add_sym(i[0] ? 2'b11 : 2'b00);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({sym_ready, data_out, mix_en, busy, sym_count, underflow_cnt} !== 29'd0) begin
                fails++;
                $display("FAIL reset_state: got rdy=%0b data=%0d mix=%0b busy=%0b cnt=%0d uf=%0d, want all 0",
                         sym_ready, data_out, mix_en, busy, sym_count, underflow_cnt);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sym_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after: got %0b want 1", sym_ready);
        end
    endtask

    task automatic test_basic();
        bit done = 0;
        obs.delete(); expv.delete(); gap_pct = 0;
        pend = '{3'b001, 3'b010, 3'b111};
        add_preamble(); add_sym(2'b01); add_sym(2'b10); add_sym(2'b11);
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            tests++;
            if ({data_out, mix_en, busy, sym_ready, sym_count, underflow_cnt} !==
                {m_data, m_mix, m_mode != 0, !rst && mq.size() < FIFO_DEPTH, m_cnt, m_uf}) begin
                fails++;
                $display("FAIL basic_cycle t=%0t: got data=%0d mix=%0b busy=%0b rdy=%0b cnt=%0d uf=%0d, want data=%0d mix=%0b busy=%0b rdy=%0b cnt=%0d uf=%0d",
                         $time, data_out, mix_en, busy, sym_ready, sym_count, underflow_cnt,
                         m_data, m_mix, m_mode != 0, !rst && mq.size() < FIFO_DEPTH, m_cnt, m_uf);
            end
            if (mix_en === 1'b1) obs.push_back(data_out);
            if (obs.size() > 0 && mix_en === 1'b0) done = 1;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL basic_timeout: burst never ended (got %0d on-air cycles)", obs.size()); end
        tests++;
        if (obs.size() != expv.size()) begin
            fails++; $display("FAIL basic_len: got %0d on-air cycles want %0d", obs.size(), expv.size());
        end else foreach (expv[i]) begin
            tests++;
            if (obs[i] !== expv[i]) begin fails++; $display("FAIL basic_seq[%0d]: got %0d want %0d", i, obs[i], expv[i]); end
        end
        tests++;
        if (sym_count !== 16'd3) begin fails++; $display("FAIL basic_count: got %0d want 3", sym_count); end
    endtask

    task automatic test_fill();
        bit done = 0;
        bit chk = 0;
        logic [1:0] s;
        obs.delete(); expv.delete(); gap_pct = 0;
        add_preamble();
        for (int c = 0; c < 64; c++) begin
            @(posedge clk);
            if (sample_tick && carrier_zero) break;
        end
        for (int k = 0; k < 5; k++) begin
            s = 2'($urandom_range(3));
            pend.push_back({k == 4, s});
            add_sym(s);
        end
        for (int c = 0; c < 600 && !done; c++) begin
            step();
            if (pend.size() == 1 && !chk) begin
                chk = 1;
                tests++;
                if (sym_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_full: got %0b want 0", sym_ready); end
            end
            if (mix_en === 1'b1) obs.push_back(data_out);
            if (obs.size() > 0 && mix_en === 1'b0) done = 1;
        end
        tests++;
        if (!done || !chk) begin fails++; $display("FAIL fill_timeout: done=%0b full_seen=%0b want 1 1", done, chk); end
        tests++;
        if (obs.size() != expv.size()) begin
            fails++; $display("FAIL fill_len: got %0d on-air cycles want %0d", obs.size(), expv.size());
        end else foreach (expv[i]) begin
            tests++;
            if (obs[i] !== expv[i]) begin fails++; $display("FAIL fill_seq[%0d]: got %0d want %0d", i, obs[i], expv[i]); end
        end
        tests++;
        if (sym_count !== 16'd8) begin fails++; $display("FAIL fill_count: got %0d want 8", sym_count); end
    endtask

    task automatic test_underflow();
        bit done = 0;
        bit pushed = 0;
        obs.delete(); expv.delete(); gap_pct = 0;
        add_preamble(); add_sym(2'b01); add_sym(2'b00); add_sym(2'b10);
        pend = '{3'b001};
        for (int c = 0; c < 600 && !done; c++) begin
            step();
            if (!pushed && underflow_cnt !== 8'd0) begin
                pushed = 1;
                pend.push_back(3'b110);
                tests++;
                if ({underflow_cnt, mix_en, data_out} !== {8'd1, 1'b1, 2'b00}) begin
                    fails++;
                    $display("FAIL underflow_boundary: got uf=%0d mix=%0b data=%0d want uf=1 mix=1 data=0",
                             underflow_cnt, mix_en, data_out);
                end
            end
            if (mix_en === 1'b1) obs.push_back(data_out);
            if (obs.size() > 0 && mix_en === 1'b0) done = 1;
        end
        tests++;
        if (!done || !pushed) begin fails++; $display("FAIL underflow_timeout: done=%0b uf_seen=%0b want 1 1", done, pushed); end
        tests++;
        if (obs.size() != expv.size()) begin
            fails++; $display("FAIL underflow_len: got %0d on-air cycles want %0d", obs.size(), expv.size());
        end else foreach (expv[i]) begin
            tests++;
            if (obs[i] !== expv[i]) begin fails++; $display("FAIL underflow_seq[%0d]: got %0d want %0d", i, obs[i], expv[i]); end
        end
        tests++;
        if ({sym_count, underflow_cnt, busy} !== {16'd10, 8'd1, 1'b0}) begin
            fails++; $display("FAIL underflow_final: got cnt=%0d uf=%0d busy=%0b want 10 1 0", sym_count, underflow_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit on = 0;
        gap_pct = 0;
        pend = '{3'b001, 3'b010, 3'b011};
        for (int c = 0; c < 100 && !on; c++) begin
            step();
            if (mix_en === 1'b1) on = 1;
        end
        tests++;
        if (!on) begin fails++; $display("FAIL rstmid_start: mix_en got 0 want 1"); end
        rst = 1'b1; pend.delete(); sym_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({mix_en, busy, data_out, sym_count, underflow_cnt, sym_ready} !== 29'd0) begin
            fails++;
            $display("FAIL rstmid_state: got mix=%0b busy=%0b data=%0d cnt=%0d uf=%0d rdy=%0b want all 0",
                     mix_en, busy, data_out, sym_count, underflow_cnt, sym_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sym_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %0b want 1", sym_ready); end
        repeat (40) step();
        tests++;
        if ({busy, mix_en} !== 2'b00) begin
            fails++; $display("FAIL rstmid_drained: got busy=%0b mix=%0b want 0 0 (FIFO not emptied)", busy, mix_en);
        end
    endtask

`ifdef QAM_PREAMBLE_EN
    task automatic test_preamble();
        bit done = 0;
        obs.delete(); expv.delete(); gap_pct = 0;
        add_sym(2'b00); add_sym(2'b11); add_sym(2'b00); add_sym(2'b11); add_sym(2'b11);
        pend = '{3'b111};
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            if (mix_en === 1'b1) obs.push_back(data_out);
            if (obs.size() > 0 && mix_en === 1'b0) done = 1;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL preamble_timeout: burst never ended"); end
        tests++;
        if (obs.size() != expv.size()) begin
            fails++; $display("FAIL preamble_len: got %0d on-air cycles want %0d", obs.size(), expv.size());
        end else foreach (expv[i]) begin
            tests++;
            if (obs[i] !== expv[i]) begin fails++; $display("FAIL preamble_seq[%0d]: got %0d want %0d", i, obs[i], expv[i]); end
        end
        tests++;
        if (sym_count !== 16'd1) begin fails++; $display("FAIL preamble_count: got %0d want 1", sym_count); end
    endtask
`endif

    task automatic test_random();
        localparam int N = 40;
        bit done = 0;
        gap_pct = 40;
        for (int k = 0; k < N; k++)
            pend.push_back({($urandom_range(3) == 0) || (k == N - 1), 2'($urandom_range(3))});
        for (int c = 0; c < 8000 && !done; c++) begin
            step();
            tests++;
            if ({data_out, mix_en, busy, sym_ready, sym_count, underflow_cnt} !==
                {m_data, m_mix, m_mode != 0, !rst && mq.size() < FIFO_DEPTH, m_cnt, m_uf}) begin
                fails++;
                $display("FAIL random_cycle t=%0t: got data=%0d mix=%0b busy=%0b rdy=%0b cnt=%0d uf=%0d, want data=%0d mix=%0b busy=%0b rdy=%0b cnt=%0d uf=%0d",
                         $time, data_out, mix_en, busy, sym_ready, sym_count, underflow_cnt,
                         m_data, m_mix, m_mode != 0, !rst && mq.size() < FIFO_DEPTH, m_cnt, m_uf);
            end
            if (pend.size() == 0 && !sym_valid && m_mode == 0 && mq.size() == 0) done = 1;
        end
        tests++;
        if (!done) begin fails++; $display("FAIL random_timeout: %0d symbols still pending", pend.size() + mq.size()); end
        tests++;
        if (sym_count !== 16'(N + (PRE > 0 ? 1 : 0))) begin
            fails++; $display("FAIL random_count: got %0d want %0d", sym_count, N + (PRE > 0 ? 1 : 0));
        end
    endtask

    initial begin
        rst = 1'b1; sym_valid = 1'b0; sym_in = 2'b00; sym_last = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_reset_mid();
`ifdef QAM_PREAMBLE_EN
        test_preamble();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/qam_symbol_scheduler.md
Name: qam_symbol_scheduler

Overview:
Sequences 2-bit QAM symbols into qam_mixer's data_in. Buffers symbols from an upstream source through a valid/ready handshake in a small internal FIFO. Starts each burst aligned to carrier phase zero from sin_cos, and holds each symbol for a fixed number of carrier samples. Ends each burst on a tagged last symbol and reports underflow when the FIFO runs dry mid-burst.

Parameters:
SYM_LEN, 16, carrier samples per symbol (>=2).
FIFO_DEPTH, 4, symbol FIFO entries (power of 2, >=2).
PREAMBLE_LEN, 8, preamble symbols per burst (used only with QAM_PREAMBLE_EN).

Ports:
clk  input  1  single system clock.
rst  input  1  synchronous reset, active-high.
sample_tick  input  1  one-cycle pulse per carrier sample (sin_cos update rate).
carrier_zero  input  1  high while sin_cos is at phase index 0.
sym_in  input  2  upstream symbol.
sym_last  input  1  marks sym_in as the final symbol of a burst.
sym_valid  input  1  upstream holds sym_in/sym_last valid.
sym_ready  output  1  FIFO can accept (= not full).
data_out  output  2  symbol to qam_mixer data_in.
mix_en  output  1  high while a burst is on air.
busy  output  1  state != IDLE.
sym_count  output  16  data symbols transmitted since reset; wraps.
underflow_cnt  output  8  underflow boundaries since reset; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; state=IDLE.
  - data_out=2'b00, mix_en=0, sym_count=0, underflow_cnt=0, tick counter=0.
  - sym_ready=0 while rst is high, and 1 on the first cycle after.
  - Reset mid-burst aborts the burst immediately; there is no drain.
- FIFO:
  - Entry = {last, sym}, 3 bits.
  - Push on sym_valid & sym_ready. sym_ready depends only on full, so a push while full is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: both happen, occupancy unchanged.
- States:
  - IDLE -> ALIGN when the FIFO is non-empty.
  - ALIGN: wait for sample_tick & carrier_zero in the same cycle, then start the burst. tick_cnt<=0, mix_en<=1.
    - Without preamble: pop the head; data_out<=head.sym; sym_count+1; -> DATA.
    - With preamble: see Optional Feature; -> PREAMBLE.
  - DATA: each sample_tick increments tick_cnt. A boundary is sample_tick & tick_cnt==SYM_LEN-1; at a boundary tick_cnt<=0. Boundary actions, in priority order:
    1. Symbol just completed had last=1: mix_en<=0, data_out<=00, -> IDLE. If the FIFO is non-empty, the next cycle goes to ALIGN; the next burst re-aligns.
    2. FIFO non-empty: pop, data_out<=sym, sym_count+1; the popped last flag is kept for the next boundary.
    3. FIFO empty (underflow): data_out<=00, mix_en stays 1, underflow_cnt+1 (saturating). The filler symbol counts as last=0.
- Latency:
  - data_out/mix_en update on the clk edge of the qualifying cycle, so they are visible the cycle after the tick.
  - Each symbol is held for exactly SYM_LEN sample_ticks.
- Edge cases:
  - carrier_zero without sample_tick is ignored.
  - sample_tick with rst high is ignored.
  - Upstream may push during DATA; a symbol arriving in the same cycle as a boundary with the FIFO empty is not used at that boundary (underflow is recorded).

Optional Feature:
QAM_PREAMBLE_EN
- Defined:
  - ALIGN goes to PREAMBLE instead of popping.
  - PREAMBLE emits PREAMBLE_LEN symbols with pattern {i[0],i[0]} for i=0..PREAMBLE_LEN-1 (00,11,00,11,...). Each symbol is held SYM_LEN ticks; the FIFO is not popped.
  - At the boundary ending the last preamble symbol, the DATA rules 2/3 apply: pop the first data symbol or underflow. Then -> DATA.
  - sym_count is not incremented for preamble symbols.
- Undefined: no PREAMBLE state; PREAMBLE_LEN is unused; ALIGN pops directly.

Test Plan:
(Defaults SYM_LEN=4, FIFO_DEPTH=4, macro off unless stated; sample_tick every 2nd cycle; carrier_zero on every 8th tick.)
1. Reset: hold rst 3 cycles -> data_out=00, mix_en=0, busy=0, sym_ready=0 during rst, then 1 the next cycle.
2. Push 1,2,3(last) before alignment -> nothing changes until the first tick with carrier_zero. Then data_out=01,10,11, each held 4 ticks (8 cycles). mix_en falls at the 3rd boundary; sym_count=3.
3. Push 5 symbols back-to-back -> sym_ready=0 after the 4th. The 5th is accepted only after the first pop; order is preserved.
4. Push 1 symbol (not last), then nothing -> at the next boundary data_out=00, underflow_cnt=1, mix_en=1. Push 2(last) -> sent at the following boundary, then IDLE.
5. Assert rst mid-DATA with 2 symbols queued -> next cycle mix_en=0, FIFO empty, sym_count=0, state IDLE.
6. QAM_PREAMBLE_EN, PREAMBLE_LEN=4, push 3(last) -> data_out=00,11,00,11 then 11, 4 ticks each. sym_count=1; mix_en low after 5 symbols.
